// File: rtl/rocc_txn_tracker.sv
// rtl/rocc_txn_tracker.sv - in-order RoCC command tracker with flush kill and response watchdog
module rocc_txn_tracker #(
    parameter int          DEPTH          = 4,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [63:0] EXC_CAUSE      = 64'd2,
    parameter int          TRANS_ID_BITS  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [TRANS_ID_BITS-1:0]   cmd_trans_id_i,
    output logic                       acc_cmd_valid_o,
    input  logic                       acc_cmd_ready_i,
    input  logic                       acc_resp_valid_i,
    output logic                       acc_resp_ready_o,
    input  logic [63:0]                acc_resp_data_i,
    output logic                       wb_valid_o,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [63:0]                wb_result_o,
    output logic                       wb_exc_valid_o,
    output logic [63:0]                wb_exc_cause_o,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       spurious_o,
    output logic                       error_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LIM = WW'(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WAIT_MAX = '1;

    typedef enum logic {ST_RUN, ST_ERROR} state_e;

    state_e                   state_q, state_d;
    logic [TRANS_ID_BITS-1:0] id_q [DEPTH];
    logic [DEPTH-1:0]         kill_q, kill_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [WW-1:0]            wait_q, wait_d;

    logic                     wb_valid_q, wb_valid_d;
    logic [TRANS_ID_BITS-1:0] wb_id_q, wb_id_d;
    logic [63:0]              wb_result_q, wb_result_d;
    logic                     wb_exc_q, wb_exc_d;
    logic [63:0]              wb_cause_q, wb_cause_d;
    logic                     spurious_q, spurious_d;

    logic running, empty, full, push, resp_pop, timeout, pop, head_kill;

    assign running   = (state_q == ST_RUN);
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign head_kill = kill_q[rd_ptr_q] | flush_i;

    assign acc_cmd_valid_o  = running & cmd_valid_i & ~full & ~flush_i;
    assign cmd_ready_o      = running & acc_cmd_ready_i & ~full & ~flush_i;
    assign acc_resp_ready_o = 1'b1;

    assign push     = cmd_valid_i & cmd_ready_o;
    assign resp_pop = running & acc_resp_valid_i & ~empty;
    // A response in the same cycle always beats the watchdog.
    assign timeout  = running & (TIMEOUT_CYCLES != 0) & ~empty & (wait_q == WAIT_LIM) & ~acc_resp_valid_i;
    assign pop      = resp_pop | timeout;

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wait_d      = wait_q;
        wb_valid_d  = 1'b0;
        wb_id_d     = wb_id_q;
        wb_result_d = wb_result_q;
        wb_exc_d    = 1'b0;
        wb_cause_d  = wb_cause_q;
        spurious_d  = 1'b0;

        if (!running) begin
            if (flush_i) begin
                state_d  = ST_RUN;
                kill_d   = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
                wait_d   = '0;
            end
        end else begin
            // Killed entries stay queued: their responses still have to be drained.
            if (flush_i) kill_d = '1;
            if (push) begin
                kill_d[wr_ptr_q] = 1'b0;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);

            if (resp_pop && !head_kill) begin
                wb_valid_d  = 1'b1;
                wb_id_d     = id_q[rd_ptr_q];
                wb_result_d = acc_resp_data_i;
                wb_cause_d  = '0;
            end
            if (timeout) begin
                state_d = ST_ERROR;
                if (!head_kill) begin
                    wb_valid_d  = 1'b1;
                    wb_id_d     = id_q[rd_ptr_q];
                    wb_result_d = '0;
                    wb_exc_d    = 1'b1;
                    wb_cause_d  = EXC_CAUSE;
                end
            end
            if (acc_resp_valid_i && empty) spurious_d = 1'b1;

            if (pop || empty)          wait_d = '0;
            else if (wait_q != WAIT_MAX) wait_d = wait_q + WW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            kill_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wait_q      <= '0;
            wb_valid_q  <= 1'b0;
            wb_id_q     <= '0;
            wb_result_q <= '0;
            wb_exc_q    <= 1'b0;
            wb_cause_q  <= '0;
            spurious_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) id_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wait_q      <= wait_d;
            wb_valid_q  <= wb_valid_d;
            wb_id_q     <= wb_id_d;
            wb_result_q <= wb_result_d;
            wb_exc_q    <= wb_exc_d;
            wb_cause_q  <= wb_cause_d;
            spurious_q  <= spurious_d;
            if (push) id_q[wr_ptr_q] <= cmd_trans_id_i;
        end
    end

    assign wb_valid_o     = wb_valid_q;
    assign wb_trans_id_o  = wb_id_q;
    assign wb_result_o    = wb_result_q;
    assign wb_exc_valid_o = wb_exc_q;
    assign wb_exc_cause_o = wb_cause_q;
    assign outstanding_o  = count_q;
    assign spurious_o     = spurious_q;
    assign error_o        = (state_q == ST_ERROR);

endmodule

// File: tb/tb_rocc_txn_tracker.sv
// tb/tb_rocc_txn_tracker.sv - randomized and directed checks of rocc_txn_tracker against a queue model
module tb_rocc_txn_tracker;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_id = '0;
    logic        acc_cmd_valid;
    logic        acc_cmd_ready = 1'b0;
    logic        acc_resp_valid = 1'b0;
    logic        acc_resp_ready;
    logic [63:0] resp_data = '0;
    logic        wb_valid;
    logic [3:0]  wb_id;
    logic [63:0] wb_result;
    logic        wb_exc;
    logic [63:0] wb_cause;
    logic [2:0]  outstanding;
    logic        spurious;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    rocc_txn_tracker #(
        .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .EXC_CAUSE(64'd2), .TRANS_ID_BITS(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_trans_id_i(cmd_id),
        .acc_cmd_valid_o(acc_cmd_valid), .acc_cmd_ready_i(acc_cmd_ready),
        .acc_resp_valid_i(acc_resp_valid), .acc_resp_ready_o(acc_resp_ready),
        .acc_resp_data_i(resp_data),
        .wb_valid_o(wb_valid), .wb_trans_id_o(wb_id), .wb_result_o(wb_result),
        .wb_exc_valid_o(wb_exc), .wb_exc_cause_o(wb_cause),
        .outstanding_o(outstanding), .spurious_o(spurious), .error_o(error)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of outstanding commands plus the cycle count the head has waited.
    typedef struct packed { logic [3:0] id; logic kill; } ent_t;
    ent_t        mq[$];
    bit          m_err;
    int          m_wait;
    bit          m_wbv, m_exc, m_spur;
    logic [3:0]  m_id;
    logic [63:0] m_res, m_cause;

    function automatic void m_reset();
        mq.delete();
        m_err = 0; m_wait = 0; m_wbv = 0; m_exc = 0; m_spur = 0;
        m_id = '0; m_res = '0; m_cause = '0;
    endfunction

    function automatic bit m_ready();
        return !m_err && acc_cmd_ready && (mq.size() < DEPTH) && !flush;
    endfunction

    function automatic bit m_acc_valid();
        return !m_err && cmd_valid && (mq.size() < DEPTH) && !flush;
    endfunction

    task automatic drive(input bit cv, input logic [3:0] id, input bit ar,
                         input bit rv, input logic [63:0] rd, input bit fl);
        cmd_valid = cv; cmd_id = id; acc_cmd_ready = ar;
        acc_resp_valid = rv; resp_data = rd; flush = fl;
        #1;
    endtask

    task automatic tick();
        bit   push, was_empty, popped, to;
        ent_t h, e;
        push = cmd_valid && m_ready();
        m_wbv = 0; m_exc = 0; m_spur = 0;
        if (m_err) begin
            if (flush) begin mq.delete(); m_wait = 0; m_err = 0; end
        end else begin
            was_empty = (mq.size() == 0);
            popped = 0;
            to = !was_empty && (m_wait == TO) && !acc_resp_valid;
            if (acc_resp_valid) begin
                if (was_empty) m_spur = 1;
                else begin
                    h = mq.pop_front(); popped = 1;
                    if (!h.kill && !flush) begin m_wbv = 1; m_id = h.id; m_res = resp_data; end
                end
            end else if (to) begin
                h = mq.pop_front(); popped = 1; m_err = 1;
                if (!h.kill && !flush) begin
                    m_wbv = 1; m_exc = 1; m_id = h.id; m_res = '0; m_cause = 64'd2;
                end
            end
            if (flush) for (int i = 0; i < mq.size(); i++) begin e = mq[i]; e.kill = 1'b1; mq[i] = e; end
            if (push) begin e.id = cmd_id; e.kill = 1'b0; mq.push_back(e); end
            if (popped || was_empty) m_wait = 0;
            else if (m_wait < 100000) m_wait++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 0; m_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (wb_valid !== 1'b0 || wb_exc !== 1'b0 || spurious !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses wb=%b exc=%b spur=%b required 0", wb_valid, wb_exc, spurious); end
        n_tests++; if (outstanding !== 3'd0 || error !== 1'b0) begin
            n_fail++; $display("FAIL reset_state outstanding=%0d error=%b required 0/0", outstanding, error); end
        n_tests++; if (acc_resp_ready !== 1'b1 || wb_result !== 64'd0 || wb_cause !== 64'd0 || wb_id !== 4'd0) begin
            n_fail++; $display("FAIL reset_outputs resp_ready=%b result=%h cause=%h id=%0d", acc_resp_ready, wb_result, wb_cause, wb_id); end
        rst_n = 1;
        drive(1, 4'd9, 1, 0, 0, 0); tick();
        drive(1, 4'd10, 1, 0, 0, 0); tick();
        n_tests++; if (outstanding !== 3'd2) begin
            n_fail++; $display("FAIL reset_pre_count outstanding=%0d required 2", outstanding); end
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 0; m_reset();
        #1;
        n_tests++; if (outstanding !== 3'd0) begin
            n_fail++; $display("FAIL reset_async outstanding=%0d required 0", outstanding); end
        @(posedge clk); #1 rst_n = 1;
        tick();
        n_tests++; if (outstanding !== 3'd0 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_discard outstanding=%0d wb=%b required 0/0", outstanding, wb_valid); end
    endtask

    task automatic test_basic();
        drive(1, 4'd5, 1, 0, 0, 0);
        n_tests++; if (cmd_ready !== 1'b1 || acc_cmd_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_issue ready=%b acc_valid=%b required 1/1", cmd_ready, acc_cmd_valid); end
        tick();
        drive(0, 0, 1, 0, 0, 0); tick(); tick();
        n_tests++; if (outstanding !== 3'd1 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_pending outstanding=%0d wb=%b required 1/0", outstanding, wb_valid); end
        drive(0, 0, 1, 1, 64'hDEADBEEF, 0); tick();
        n_tests++; if (wb_valid !== 1'b1 || wb_id !== 4'd5 || wb_result !== 64'hDEADBEEF || wb_exc !== 1'b0) begin
            n_fail++; $display("FAIL basic_wb valid=%b id=%0d result=%h exc=%b required 1/5/deadbeef/0", wb_valid, wb_id, wb_result, wb_exc); end
        n_tests++; if (outstanding !== 3'd0) begin
            n_fail++; $display("FAIL basic_count outstanding=%0d required 0", outstanding); end
        drive(0, 0, 1, 0, 0, 0); tick();
        n_tests++; if (wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_pulse wb=%b required 0", wb_valid); end
    endtask

    task automatic test_full();
        logic [3:0] base, want;
        for (int r = 0; r < 3; r++) begin
            base = 4'(r * 5 + 1);
            for (int k = 0; k < DEPTH; k++) begin drive(1, base + 4'(k), 1, 0, 0, 0); tick(); end
            drive(1, base + 4'd4, 1, 0, 0, 0);
            n_tests++; if (cmd_ready !== 1'b0 || acc_cmd_valid !== 1'b0 || outstanding !== 3'd4) begin
                n_fail++; $display("FAIL full_block r%0d ready=%b acc_valid=%b outstanding=%0d required 0/0/4", r, cmd_ready, acc_cmd_valid, outstanding); end
            drive(1, base + 4'd4, 1, 1, 64'(r), 0);
            n_tests++; if (cmd_ready !== 1'b0) begin
                n_fail++; $display("FAIL full_no_bypass r%0d ready=%b required 0", r, cmd_ready); end
            tick();
            n_tests++; if (wb_valid !== 1'b1 || wb_id !== base) begin
                n_fail++; $display("FAIL full_retire r%0d wb=%b id=%0d required 1/%0d", r, wb_valid, wb_id, base); end
            drive(1, base + 4'd4, 1, 0, 0, 0);
            n_tests++; if (cmd_ready !== 1'b1) begin
                n_fail++; $display("FAIL full_reopen r%0d ready=%b required 1", r, cmd_ready); end
            tick();
            for (int k = 1; k <= DEPTH; k++) begin
                drive(0, 0, 1, 1, 64'(k), 0); tick();
                want = base + 4'(k);
                n_tests++; if (wb_valid !== 1'b1 || wb_id !== want) begin
                    n_fail++; $display("FAIL full_drain r%0d k%0d wb=%b id=%0d required 1/%0d", r, k, wb_valid, wb_id, want); end
            end
            n_tests++; if (outstanding !== 3'd0) begin
                n_fail++; $display("FAIL full_empty r%0d outstanding=%0d required 0", r, outstanding); end
        end
        drive(0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'd3, 0, 0, 0, 0);
            n_tests++; if (cmd_ready !== 1'b0 || acc_cmd_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_ready c%0d ready=%b acc_valid=%b required 0/1", i, cmd_ready, acc_cmd_valid); end
            tick();
            n_tests++; if (outstanding !== 3'd0) begin
                n_fail++; $display("FAIL bp_count c%0d outstanding=%0d required 0", i, outstanding); end
        end
    endtask

    task automatic test_flush();
        logic [63:0] d;
        drive(1, 4'd2, 1, 0, 0, 0); tick();
        drive(1, 4'd3, 1, 0, 0, 0); tick();
        drive(1, 4'd8, 1, 0, 0, 1);
        n_tests++; if (cmd_ready !== 1'b0 || acc_cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_gate ready=%b acc_valid=%b required 0/0", cmd_ready, acc_cmd_valid); end
        tick();
        n_tests++; if (outstanding !== 3'd2) begin
            n_fail++; $display("FAIL flush_keep outstanding=%0d required 2", outstanding); end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 1, 64'h55, 0); tick();
            n_tests++; if (wb_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_killed r%0d wb=%b required 0", i, wb_valid); end
        end
        n_tests++; if (outstanding !== 3'd0 || spurious !== 1'b0) begin
            n_fail++; $display("FAIL flush_drained outstanding=%0d spur=%b required 0/0", outstanding, spurious); end
        drive(1, 4'd6, 1, 0, 0, 0); tick();
        d = {$urandom, $urandom};
        drive(0, 0, 1, 1, d, 0); tick();
        n_tests++; if (wb_valid !== 1'b1 || wb_id !== 4'd6 || wb_result !== d) begin
            n_fail++; $display("FAIL flush_after wb=%b id=%0d result=%h required 1/6/%h", wb_valid, wb_id, wb_result, d); end
        drive(1, 4'd4, 1, 0, 0, 0); tick();
        drive(0, 0, 1, 1, 64'h77, 1); tick();
        n_tests++; if (wb_valid !== 1'b0 || outstanding !== 3'd0) begin
            n_fail++; $display("FAIL flush_same_cycle wb=%b outstanding=%0d required 0/0", wb_valid, outstanding); end
        drive(0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_spurious();
        drive(0, 0, 1, 1, 64'h99, 0); tick();
        n_tests++; if (spurious !== 1'b1 || wb_valid !== 1'b0 || error !== 1'b0) begin
            n_fail++; $display("FAIL spur_pulse spur=%b wb=%b err=%b required 1/0/0", spurious, wb_valid, error); end
        drive(0, 0, 1, 0, 0, 0); tick();
        n_tests++; if (spurious !== 1'b0 || outstanding !== 3'd0) begin
            n_fail++; $display("FAIL spur_clear spur=%b outstanding=%0d required 0/0", spurious, outstanding); end
    endtask

    task automatic test_timeout();
        drive(1, 4'd7, 1, 0, 0, 0); tick();
        for (int i = 1; i <= 9; i++) begin
            drive(0, 0, 1, 0, 0, 0); tick();
            n_tests++; if (wb_valid !== (i == 9)) begin
                n_fail++; $display("FAIL to_latency cycle%0d wb=%b required %0d", i + 1, wb_valid, (i == 9)); end
        end
        n_tests++; if (wb_exc !== 1'b1 || wb_cause !== 64'd2 || wb_result !== 64'd0 || wb_id !== 4'd7) begin
            n_fail++; $display("FAIL to_wb exc=%b cause=%0d result=%h id=%0d required 1/2/0/7", wb_exc, wb_cause, wb_result, wb_id); end
        drive(1, 4'd1, 1, 0, 0, 0);
        n_tests++; if (error !== 1'b1 || cmd_ready !== 1'b0 || acc_cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL to_error err=%b ready=%b acc_valid=%b required 1/0/0", error, cmd_ready, acc_cmd_valid); end
        drive(0, 0, 1, 1, 64'h1234, 0); tick();
        n_tests++; if (wb_valid !== 1'b0 || spurious !== 1'b0 || error !== 1'b1) begin
            n_fail++; $display("FAIL to_drop wb=%b spur=%b err=%b required 0/0/1", wb_valid, spurious, error); end
        drive(0, 0, 1, 0, 0, 1); tick();
        n_tests++; if (error !== 1'b0 || outstanding !== 3'd0) begin
            n_fail++; $display("FAIL to_recover err=%b outstanding=%0d required 0/0", error, outstanding); end
        drive(0, 0, 1, 0, 0, 0); tick();
    endtask

    task automatic test_random();
        bit exp_r, exp_v;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 1), 4'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) < 3), {$urandom, $urandom}, ($urandom_range(0, 19) == 0));
            exp_r = m_ready();
            exp_v = m_acc_valid();
            n_tests++; if (cmd_ready !== exp_r || acc_cmd_valid !== exp_v) begin
                n_fail++; $display("FAIL rnd_issue c%0d ready=%b acc_valid=%b required %b/%b", c, cmd_ready, acc_cmd_valid, exp_r, exp_v); end
            tick();
            n_tests++; if (wb_valid !== m_wbv || wb_exc !== m_exc || spurious !== m_spur) begin
                n_fail++; $display("FAIL rnd_pulse c%0d wb=%b exc=%b spur=%b required %b/%b/%b", c, wb_valid, wb_exc, spurious, m_wbv, m_exc, m_spur); end
            n_tests++; if (error !== m_err || outstanding !== 3'(mq.size())) begin
                n_fail++; $display("FAIL rnd_state c%0d err=%b outstanding=%0d required %b/%0d", c, error, outstanding, m_err, mq.size()); end
            if (m_wbv) begin
                n_tests++; if (wb_id !== m_id || wb_result !== m_res || (m_exc && wb_cause !== m_cause)) begin
                    n_fail++; $display("FAIL rnd_data c%0d id=%0d result=%h cause=%0d required %0d/%h/%0d", c, wb_id, wb_result, wb_cause, m_id, m_res, m_cause); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_backpressure();
        test_flush();
        test_spurious();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rocc_txn_tracker.md
# rocc_txn_tracker

In-order transaction tracker and sequencer between the RoCC functional-unit adapter and the external RoCC accelerator. It gates command issue on tracking capacity and records the trans_id of every accepted command. It matches each accelerator response to the oldest outstanding command and produces a registered writeback toward the scoreboard. It also handles flush by killing in-flight entries, and detects lost responses with a watchdog.

## Interface
Parameters:
- DEPTH, 4, maximum outstanding commands; power of two, ≥2
- TIMEOUT_CYCLES, 1024, watchdog limit per head entry; 0 disables the watchdog
- EXC_CAUSE, 64'd2, cause reported on timeout writeback

Ports:
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush
- cmd_valid_i  in  1  adapter presents a command
- cmd_ready_o  out  1  command accepted this cycle when high with cmd_valid_i
- cmd_trans_id_i  in  TRANS_ID_BITS  trans_id of the presented command
- acc_cmd_valid_o  out  1  command valid to the accelerator
- acc_cmd_ready_i  in  1  accelerator can take a command
- acc_resp_valid_i  in  1  accelerator response valid
- acc_resp_ready_o  out  1  tied 1; the accelerator is never back-pressured
- acc_resp_data_i  in  64  response data
- wb_valid_o  out  1  writeback valid (single-cycle pulse)
- wb_trans_id_o  out  TRANS_ID_BITS  writeback trans_id
- wb_result_o  out  64  writeback data
- wb_exc_valid_o  out  1  writeback carries an exception
- wb_exc_cause_o  out  64  exception cause
- outstanding_o  out  $clog2(DEPTH+1)  count of tracked entries, live plus killed
- spurious_o  out  1  pulse: a response was dropped because no entry was tracked
- error_o  out  1  high while in the ERROR state

## Operation
- Storage: circular FIFO of DEPTH entries `{trans_id, kill}`, with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- States: RUN and ERROR. Reset state is RUN.
- RUN, issue path:
  - acc_cmd_valid_o = cmd_valid_i & (count<DEPTH) & ~flush_i.
  - cmd_ready_o = acc_cmd_ready_i & (count<DEPTH) & ~flush_i.
  - On acceptance (cmd_valid_i & cmd_ready_o), push `{cmd_trans_id_i, 0}`.
  - No full bypass: when count==DEPTH, a same-cycle pop does not allow a push.
- RUN, response path: a response (acc_resp_valid_i) always pops the head.
  - Live head: register wb_valid_o=1, wb_trans_id_o=head id, wb_result_o=acc_resp_data_i, wb_exc_valid_o=0.
  - Killed head: pop with no writeback.
  - Empty FIFO: drop the response, pulse spurious_o next cycle, leave state unchanged.
- Flush in RUN:
  - Set kill on every entry valid at the clock edge, including a head popping in the same cycle; that pop produces no writeback.
  - FIFO contents and count are kept, because killed commands still receive responses that must be drained.
  - A wb pulse already registered before the flush cycle is not cancelled.
- Watchdog:
  - wait_cnt clears when the head changes (pop, or push into an empty FIFO) and when the FIFO is empty.
  - Otherwise wait_cnt increments by 1 per cycle and saturates.
  - Timeout event: count>0 & wait_cnt==TIMEOUT_CYCLES & no response this cycle.
  - On timeout with a live head: pop, writeback with wb_exc_valid_o=1, wb_exc_cause_o=EXC_CAUSE, wb_result_o=0.
  - On timeout with a killed head: pop, no writeback.
  - Either way, go to ERROR.
- ERROR state:
  - cmd_ready_o=0 and acc_cmd_valid_o=0.
  - All responses are dropped with no spurious pulse.
  - The watchdog is stopped.
  - flush_i clears the FIFO, pointers, count, kill bits and wait_cnt, then returns to RUN on the next cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.

## Timing
- Issue path is combinational: zero-cycle pass-through of valid/ready.
- Writeback latency: exactly 1 cycle after the response or timeout cycle. wb_* are registered.
- wb_valid_o, spurious_o and wb_exc_valid_o are high for one cycle only.
- outstanding_o and error_o are registered and reflect the previous edge.
- Reset (asynchronous, takes effect immediately):
  - All outputs register to 0, except acc_resp_ready_o which is 1.
  - State is RUN; pointers, count and wait_cnt are 0; all kill bits are cleared.
  - Reset mid-transaction discards all tracking.
- At most one writeback per cycle. A response and a timeout are never both acted on: the response wins.

## Test plan
- Basic round trip: accept trans_id 5 in cycle 0, acc_resp_data_i=0xDEADBEEF in cycle 3 -> wb_valid_o in cycle 4 with id 5 and result 0xDEADBEEF; outstanding_o goes 1 → 0.
- Full FIFO: push ids 1–4 (DEPTH=4) with no responses -> 5th command sees cmd_ready_o=0 and acc_cmd_valid_o=0. A response in cycle N retires id 1 -> 5th accepted in cycle N+1. Pointers wrap correctly over 3 fills.
- Backpressure: acc_cmd_ready_i=0 with cmd_valid_i=1 for 5 cycles -> cmd_ready_o=0 and outstanding_o=0 throughout.
- Flush: ids 2 and 3 outstanding, then flush_i for one cycle -> next 2 responses give no wb_valid_o. New id 6 accepted after the flush, then its response -> wb id 6. Also cover a response in the flush cycle -> no writeback.
- Timeout: TIMEOUT_CYCLES=8, accept id 7 in cycle 0, no response -> wb_valid_o in cycle 10 with wb_exc_valid_o=1 and cause 2; error_o=1 and cmd_ready_o=0. A response in ERROR is dropped. flush_i -> RUN with outstanding_o=0.
- Spurious response: acc_resp_valid_i with an empty FIFO -> spurious_o pulses one cycle later, no wb_valid_o, state stays RUN.
